// File: rtl/rf_ctx_seq.sv
// Context save/restore sequencer: streams R0..R(NREGS-1) between the register
// file and a block of byte-addressed data memory over a req/ack handshake.
module rf_ctx_seq #(
  parameter int NREGS  = 8,
  parameter int STRIDE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        save_req,
  input  logic        restore_req,
  input  logic [15:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic [2:0]  rf_read1regsel,
  input  logic [15:0] rf_read1data,
  output logic [2:0]  rf_writeregsel,
  output logic [15:0] rf_writedata,
  output logic        rf_write,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_RD,
    S_SAVE_WR,
    S_REST_RQ,
    S_REST_WB,
    S_DONE
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'(NREGS - 1);
  localparam logic [15:0] STEP     = 16'(STRIDE);

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] addr, addr_nxt;
  logic [15:0] data_buf, data_buf_nxt;

  // NOTE: every register here has a defined reset value; the datapath is a
  // handful of flops, so there is no reason to leave any of them unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      addr     <= '0;
      data_buf <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nxt;
      idx      <= idx_nxt;
      addr     <= addr_nxt;
      data_buf <= data_buf_nxt;
    end
  end

  // Outputs are decoded from state only, so an asynchronous reset forces all
  // of them to zero at once and aborts any transfer in flight.
  always_comb begin
    // NOTE: defaults first so no path through the case statement infers a latch.
    state_nxt      = state;
    idx_nxt        = idx;
    addr_nxt       = addr;
    data_buf_nxt   = data_buf;
    busy           = 1'b0;
    done           = 1'b0;
    rf_read1regsel = '0;
    rf_writeregsel = '0;
    rf_writedata   = '0;
    rf_write       = 1'b0;
    mem_req        = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    unique case (state)
      S_IDLE: begin
        // Save has priority; a simultaneous restore request is simply dropped.
        if (save_req || restore_req) begin
          state_nxt = save_req ? S_SAVE_RD : S_REST_RQ;
          idx_nxt   = '0;
          addr_nxt  = base_addr;
        end
      end
      S_SAVE_RD: begin
        busy           = 1'b1;
        rf_read1regsel = idx;
        data_buf_nxt   = rf_read1data;
        state_nxt      = S_SAVE_WR;
      end
      S_SAVE_WR: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr;
        mem_wdata = data_buf;
        if (mem_ack) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 3'd1;
            addr_nxt  = addr + STEP;
            state_nxt = S_SAVE_RD;
          end
        end
      end
      S_REST_RQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = addr;
        if (mem_ack) begin
          data_buf_nxt = mem_rdata;
          state_nxt    = S_REST_WB;
        end
      end
      S_REST_WB: begin
        busy           = 1'b1;
        rf_write       = 1'b1;
        rf_writeregsel = idx;
        rf_writedata   = data_buf;
        if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx + 3'd1;
          addr_nxt  = addr + STEP;
          state_nxt = S_REST_RQ;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/rf_ctx_seq.md
# rf_ctx_seq

Context save/restore sequencer for the 8×16-bit register file. On request, it takes ownership of one register-file read port and the write port and streams registers R0..R(NREGS-1) to or from a block of data memory over a req/ack handshake. It sits beside the register file in the decode stage and is used for interrupt entry/exit and context switches. The core pipeline is stalled while `busy` is high.

## Interface
- `NREGS`, default 8: number of registers transferred, starting at R0. Legal range 1..8.
- `STRIDE`, default 2: address increment per register, in bytes (memory is byte-addressed, 16-bit words).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `save_req`  in  1  start save (RF→memory); sampled only in IDLE.
- `restore_req`  in  1  start restore (memory→RF); sampled only in IDLE.
- `base_addr`  in  16  memory address of R0's slot; captured when a request is accepted.
- `busy`  out  1  sequencer owns RF ports and memory port.
- `done`  out  1  one-cycle pulse at completion.
- `rf_read1regsel`  out  3  RF read-port select.
- `rf_read1data`  in  16  RF read-port data, combinational from select.
- `rf_writeregsel`  out  3  RF write select.
- `rf_writedata`  out  16  RF write data.
- `rf_write`  out  1  RF write enable.
- `mem_req`  out  1  memory request.
- `mem_wr`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  memory write data.
- `mem_ack`  in  1  memory accepts/completes the request this cycle.
- `mem_rdata`  in  16  read data; valid in a cycle with `mem_ack` high on a read.

## Operation
- States: IDLE, SAVE_RD, SAVE_WR, REST_RQ, REST_WB, DONE. 3-bit index `idx`; 16-bit `addr` and `buf` registers.
- **IDLE:**
  - `save_req` → SAVE_RD.
  - Else `restore_req` → REST_RQ.
  - When both are high, save wins and the restore request is dropped.
  - On acceptance: `idx`=0, `addr`=`base_addr`.
- **SAVE_RD:** `rf_read1regsel`=`idx`; `buf`<=`rf_read1data`; → SAVE_WR.
- **SAVE_WR:** `mem_req`=1, `mem_wr`=1, `mem_addr`=`addr`, `mem_wdata`=`buf`. Hold until `mem_ack`=1. On ack:
  - If `idx`==NREGS-1 → DONE.
  - Else `idx`+=1, `addr`+=STRIDE, → SAVE_RD.
- **REST_RQ:** `mem_req`=1, `mem_wr`=0, `mem_addr`=`addr`. On `mem_ack`: `buf`<=`mem_rdata`, → REST_WB.
- **REST_WB:** `rf_write`=1, `rf_writeregsel`=`idx`, `rf_writedata`=`buf`. Then:
  - If last → DONE.
  - Else increment `idx`/`addr` as above, → REST_RQ.
- **DONE:** `done`=1, `busy`=0; → IDLE. Requests are not sampled in DONE.
- `busy`=1 in every state except IDLE and DONE.
- Address arithmetic is 16-bit modulo 2^16; wrap past 0xFFFF is silent.
- `mem_addr`, `mem_wr` and `mem_wdata` are stable throughout a request until ack.
- `mem_ack` while `mem_req`=0 is ignored.
- `rf_write` is never asserted outside REST_WB. `mem_req` is never asserted outside SAVE_WR and REST_RQ.
- Requests arriving while busy or in DONE are ignored and not queued.

## Timing
- Reset (asynchronous assert): state IDLE, `idx`=0, `addr`=0, `buf`=0. All outputs are 0, including `rf_*` selects/data and `mem_*`.
  - Reset mid-transfer aborts immediately: no further RF write or memory request, and no `done`.
  - Memory and RF keep whatever was already written.
- Reset is released synchronously to `clk` by the system; the first request is accepted on the first edge after deassertion.
- Cycle 0 = edge where a request is sampled in IDLE. `busy` is high from cycle 1.
- Save with zero-wait ack: 2 cycles per register. For NREGS=8, the last ack is in cycle 16, `done` in cycle 17, and IDLE in cycle 18.
- Restore: same count. Each register's RF write happens the cycle after its ack.
- Each memory wait cycle adds exactly one cycle.

## Test plan
- **Save, zero-wait:** R0..R7 = 0x1000+i, base 0x0200, ack tied high.
  - Required: 8 writes to 0x0200, 0x0202, …, 0x020E with data 0x1000..0x1007.
  - `done` in cycle 17; `busy` high for cycles 1–16 only.
- **Restore with waits:** memory at 0x0400.. holds 0xA000+i; ack delayed 3 cycles per request.
  - Required: R0..R7 = 0xA000..0xA007; address/`mem_wr` stable during waits; `done` in cycle 41.
- **Simultaneous requests:** `save_req` and `restore_req` high together.
  - Required: only writes (`mem_wr`=1) occur; no `rf_write` pulses.
  - A request held high through DONE is not accepted until IDLE.
- **Wrap and NREGS=3:** base 0xFFFC, save.
  - Required: writes to 0xFFFC, 0xFFFE, 0x0000; `done` after 3 acks.
- **Reset mid-restore:** assert `rst` low during REST_WB of R4.
  - Required: all outputs 0 immediately, R0..R3 restored, R5..R7 unchanged, no `done`.
  - A new save after release completes normally.
- **Spurious ack:** `mem_ack` pulses in IDLE and during SAVE_RD.
  - Required: no state advance and no `buf` capture from `mem_rdata`.
